// File: rtl/systolic_sequencer_pkg.sv
// Shared types and defaults for the systolic array sequencer.
// Holds the FSM state encoding and the lane-packing helper used across the slice.
package systolic_sequencer_pkg;

    localparam int DEF_N      = 2;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ACC_W  = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    // Bit offset of lane idx inside a flat bus of width-bit lanes.
    function automatic int lane_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/systolic_operand_buf.sv
// A and B operand register files with a single write port and a skewed,
// registered read that produces the diagonal wavefront fed into the array.
module systolic_operand_buf
    import systolic_sequencer_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = $clog2(2 * N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   feed_en,
    input  logic [CNT_W-1:0]       feed_t,
    output logic [N*DATA_W-1:0]    a_feed,
    output logic [N*DATA_W-1:0]    b_feed
);

    logic [DATA_W-1:0]   a_mem [N][N];
    logic [DATA_W-1:0]   b_mem [N][N];
    logic [N*DATA_W-1:0] a_next;
    logic [N*DATA_W-1:0] b_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            if (wr_sel) begin
                b_mem[wr_row][wr_col] <= wr_data;
            end else begin
                a_mem[wr_row][wr_col] <= wr_data;
            end
        end
    end

    // Lane gi carries row gi of A (column gi of B) delayed by gi cycles.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [DATA_W-1:0] a_lane;
            logic [DATA_W-1:0] b_lane;

            always_comb begin
                a_lane = '0;
                b_lane = '0;
                if (feed_en) begin
                    for (int k = 0; k < N; k++) begin
                        if (int'(feed_t) == gi + k) begin
                            a_lane = a_mem[gi][k];
                            b_lane = b_mem[k][gi];
                        end
                    end
                end
            end

            assign a_next[lane_lsb(gi, DATA_W) +: DATA_W] = a_lane;
            assign b_next[lane_lsb(gi, DATA_W) +: DATA_W] = b_lane;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_feed <= '0;
            b_feed <= '0;
        end else begin
            a_feed <= a_next;
            b_feed <= b_next;
        end
    end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequencer for an external output-stationary N x N systolic array: clears the
// accumulators, streams skewed operands, waits for the wavefront to drain, captures C.
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [$clog2(N)-1:0]   wr_row,
    input  logic [$clog2(N)-1:0]   wr_col,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   arr_clr,
    output logic [N*DATA_W-1:0]    a_feed,
    output logic [N*DATA_W-1:0]    b_feed,
    input  logic [N*N*ACC_W-1:0]   arr_result,
    output logic [N*N*ACC_W-1:0]   result_q
);

    localparam int              CNT_W      = $clog2(2 * N);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * N - 2);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        busy       = 1'b1;
        done       = 1'b0;
        arr_clr    = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                arr_clr    = 1'b1;
                state_next = FEED;
                cnt_next   = '0;
            end
            FEED: begin
                if (cnt_reg == FEED_LAST) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_reg == DRAIN_LAST) begin
                    state_next = DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Feeds are registered, so they are computed from the upcoming state/count.
    systolic_operand_buf #(
        .N      (N),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_operand_buf (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en && !busy),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .feed_en (state_next == FEED),
        .feed_t  (cnt_next),
        .a_feed  (a_feed),
        .b_feed  (b_feed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
        end else if (state_reg == DONE) begin
            result_q <= arr_result;
        end
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Self-checking bench: table-driven cases, corner sequences and random matrices,
// with a simple output-stationary array model driving arr_result.
module tb_systolic_sequencer;
    import systolic_sequencer_pkg::*;

    localparam int N      = 2;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int AW     = $clog2(N);

    typedef logic [N-1:0][N-1:0][DATA_W-1:0] mat_t;
    typedef logic [N-1:0][N-1:0][ACC_W-1:0]  res_t;
    typedef struct {
        mat_t a;
        mat_t b;
        res_t c;
        bit   rerun;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 wr_en = 1'b0;
    logic                 wr_sel = 1'b0;
    logic [AW-1:0]        wr_row = '0;
    logic [AW-1:0]        wr_col = '0;
    logic [DATA_W-1:0]    wr_data = '0;
    logic                 start = 1'b0;
    logic                 busy, done, arr_clr;
    logic [N*DATA_W-1:0]  a_feed, b_feed;
    logic [N*N*ACC_W-1:0] arr_result, result_q;

    int   errors = 0;
    int   checks = 0;
    int   cycle = 0;
    mat_t a_m = '0;
    mat_t b_m = '0;

    systolic_sequencer #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .arr_clr    (arr_clr),
        .a_feed     (a_feed),
        .b_feed     (b_feed),
        .arr_result (arr_result),
        .result_q   (result_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // External array: PE(i,j) sees row i delayed j cycles and column j delayed i cycles.
    logic [DATA_W-1:0] a_pipe [N][N];
    logic [DATA_W-1:0] b_pipe [N][N];
    logic [ACC_W-1:0]  acc    [N][N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                automatic int jl = (j == 0) ? 0 : j - 1;
                automatic int iu = (i == 0) ? 0 : i - 1;
                automatic logic [DATA_W-1:0] ai = (j == 0) ? a_feed[i*DATA_W +: DATA_W] : a_pipe[i][jl];
                automatic logic [DATA_W-1:0] bi = (i == 0) ? b_feed[j*DATA_W +: DATA_W] : b_pipe[iu][j];
                a_pipe[i][j] <= arr_clr ? '0 : ai;
                b_pipe[i][j] <= arr_clr ? '0 : bi;
                acc[i][j]    <= arr_clr ? '0 : acc[i][j] + ACC_W'(ai) * ACC_W'(bi);
            end
        end
    end

    always_comb begin
        arr_result = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                arr_result[lane_lsb(i * N + j, ACC_W) +: ACC_W] = acc[i][j];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic mat_t mk(input int m00, input int m01, input int m10, input int m11);
        mat_t m;
        m[0][0] = DATA_W'(m00); m[0][1] = DATA_W'(m01);
        m[1][0] = DATA_W'(m10); m[1][1] = DATA_W'(m11);
        return m;
    endfunction

    function automatic res_t mkr(input int c00, input int c01, input int c10, input int c11);
        res_t r;
        r[0][0] = ACC_W'(c00); r[0][1] = ACC_W'(c01);
        r[1][0] = ACC_W'(c10); r[1][1] = ACC_W'(c11);
        return r;
    endfunction

    function automatic res_t matmul(input mat_t a, input mat_t b);
        res_t c = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                for (int k = 0; k < N; k++)
                    c[i][j] = c[i][j] + ACC_W'(a[i][k]) * ACC_W'(b[k][j]);
        return c;
    endfunction

    // Wavefront at time t: lane i holds A[i][t-i], lane j holds B[t-j][j].
    function automatic logic [N*DATA_W-1:0] exp_a(input int t);
        logic [N*DATA_W-1:0] v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < N) v[i*DATA_W +: DATA_W] = a_m[i][t-i];
        return v;
    endfunction

    function automatic logic [N*DATA_W-1:0] exp_b(input int t);
        logic [N*DATA_W-1:0] v = '0;
        for (int j = 0; j < N; j++)
            if (t - j >= 0 && t - j < N) v[j*DATA_W +: DATA_W] = b_m[t-j][j];
        return v;
    endfunction

    // All drivers below start and end on a falling edge.
    task automatic wr(input logic sel, input int r, input int c, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_row = AW'(r); wr_col = AW'(c); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) b_m[r][c] = d;
        else     a_m[r][c] = d;
    endtask

    task automatic load(input mat_t a, input mat_t b);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                wr(1'b0, i, j, a[i][j]);
                wr(1'b1, i, j, b[i][j]);
            end
    endtask

    task automatic run(input string tag, input bit poke, output int done_cyc);
        res_t exp_c = matmul(a_m, b_m);
        int   c0 = cycle;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " clear"}, {busy, arr_clr, done, a_feed, b_feed}, {3'b110, {2*N*DATA_W{1'b0}}});
        for (int t = 0; t < 2 * N - 1; t++) begin
            @(negedge clk);
            chk($sformatf("%s feed_t%0d", tag, t), {busy, arr_clr, done, a_feed, b_feed},
                {3'b100, exp_a(t), exp_b(t)});
            if (poke && t == 1) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
                wr_row = '0; wr_col = '0; wr_data = 16'hDEAD;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
        end
        for (int d = 0; d < N; d++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0;
            chk($sformatf("%s drain%0d", tag, d), {busy, arr_clr, done, a_feed, b_feed},
                {3'b100, {2*N*DATA_W{1'b0}}});
        end
        @(negedge clk);
        chk({tag, " done"}, {busy, arr_clr, done, a_feed, b_feed}, {3'b101, {2*N*DATA_W{1'b0}}});
        chk({tag, " latency"}, 128'(cycle - c0), 128'(3 * N + 1));
        done_cyc = cycle;
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " idle"}, {busy, done}, 2'b00);
        chk({tag, " result"}, result_q, exp_c);
        $display("run %s: result_q=%h expected=%h", tag, result_q, exp_c);
    endtask

    vec_t tbl [4];

    initial begin
        int d1, d2;
        repeat (2) @(negedge clk);
        chk("reset ctrl", {busy, done, arr_clr, a_feed, b_feed}, '0);
        chk("reset result", result_q, '0);
        reset = 1'b1;
        @(negedge clk);

        tbl[0] = '{mk(1, 2, 3, 4), mk(1, 2, 3, 4), mkr(7, 10, 15, 22), 1'b0};
        tbl[1] = '{mk(1, 0, 0, 1), mk(5, 6, 7, 8), mkr(5, 6, 7, 8), 1'b1};
        tbl[2] = '{mk(2, 0, 0, 3), mk(1, 1, 1, 1), mkr(2, 2, 3, 3), 1'b0};
        tbl[3] = '{mk(65535, 65535, 65535, 65535), mk(65535, 65535, 65535, 65535),
                   mkr(32'hFFFC0002, 32'hFFFC0002, 32'hFFFC0002, 32'hFFFC0002), 1'b1};

        for (int v = 0; v < 4; v++) begin
            load(tbl[v].a, tbl[v].b);
            run($sformatf("tbl%0d", v), 1'b0, d1);
            chk($sformatf("tbl%0d const", v), result_q, tbl[v].c);
            if (tbl[v].rerun) begin
                run($sformatf("tbl%0d rerun", v), 1'b0, d2);
                chk($sformatf("tbl%0d rerun const", v), result_q, tbl[v].c);
                chk($sformatf("tbl%0d b2b gap", v), 128'(d2 - d1), 128'(3 * N + 2));
            end
        end

        // Start pulses in FEED and DONE plus a write while busy are all ignored.
        load(mk(1, 2, 3, 4), mk(1, 2, 3, 4));
        run("poke", 1'b1, d1);
        @(negedge clk);
        chk("poke single done", {busy, done}, 2'b00);
        run("poke after", 1'b0, d1);
        chk("poke operands kept", result_q, mkr(7, 10, 15, 22));

        // Asynchronous reset in the middle of FEED.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre-reset feed_t1", {a_feed, b_feed}, {exp_a(1), exp_b(1)});
        #1 reset = 1'b0;
        #1;
        chk("async reset ctrl", {busy, done, arr_clr, a_feed, b_feed}, '0);
        chk("async reset result", result_q, '0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("reset hold %0d", i), {busy, done}, 2'b00);
        end
        reset = 1'b1;
        a_m = '0;
        b_m = '0;
        @(negedge clk);
        run("post-reset zero", 1'b0, d1);
        load(mk(1, 2, 3, 4), mk(1, 2, 3, 4));
        run("post-reset reload", 1'b0, d1);
        chk("post-reset const", result_q, mkr(7, 10, 15, 22));

        for (int r = 0; r < 8; r++) begin
            mat_t ra, rb;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    ra[i][j] = (r < 4) ? DATA_W'($urandom_range(0, 15)) : DATA_W'($urandom);
                    rb[i][j] = (r < 4) ? DATA_W'($urandom_range(0, 15)) : DATA_W'($urandom);
                end
            load(ra, rb);
            run($sformatf("rand%0d", r), 1'b0, d1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_sequencer.md
SYSTOLIC_SEQUENCER -- requirements
Module: systolic_sequencer

Interface
REQ-001 SHALL have parameter N, default 2, meaning systolic array dimension (N x N).
REQ-002 SHALL have parameter DATA_W, default 16, meaning operand width.
REQ-003 SHALL have parameter ACC_W, default 32, meaning accumulator/result width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  operand write strobe.
REQ-007 wr_sel  input  1  0 = matrix A, 1 = matrix B.
REQ-008 wr_row, wr_col  input  $clog2(N) each  operand element address.
REQ-009 wr_data  input  DATA_W  operand value.
REQ-010 start  input  1  begin one multiply.
REQ-011 busy  output  1  high from CLEAR through DONE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 arr_clr  output  1  active-high accumulator clear to the array.
REQ-014 a_feed  output  N*DATA_W  row inputs to the array; lane i at bits [i*DATA_W +: DATA_W].
REQ-015 b_feed  output  N*DATA_W  column inputs to the array; lane j likewise.
REQ-016 arr_result  input  N*N*ACC_W  array accumulators; element (i,j) at index i*N+j.
REQ-017 result_q  output  N*N*ACC_W  captured product C = A x B, same packing.

Function
REQ-018 SHALL hold A and B in internal N x N DATA_W register files; a write with wr_en=1 and busy=0 SHALL update the addressed element on that edge.
REQ-019 wr_en while busy=1 SHALL be ignored, and operands SHALL be unchanged.
REQ-020 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, DONE.
REQ-021 IDLE: start=1 SHALL go to CLEAR; start in any other state SHALL be ignored.
REQ-022 CLEAR lasts 1 cycle with arr_clr=1, then goes to FEED with cycle counter t=0.
REQ-023 FEED lasts 2N-1 cycles (t = 0..2N-2); a_feed lane i SHALL be A[i][t-i] when 0 <= t-i < N, else 0; b_feed lane j SHALL be B[t-j][j] when 0 <= t-j < N, else 0.
REQ-024 a_feed and b_feed SHALL be registered and SHALL be 0 in all states except FEED.
REQ-025 DRAIN SHALL last N cycles, then go to DONE.
REQ-026 DONE lasts 1 cycle: done=1, result_q <= arr_result on that edge, then return to IDLE.
REQ-027 From a start sampled at edge k, done SHALL be high in cycle k+3N+1 (cycle k+7 for N=2).
REQ-028 start=1 during the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL launch a new run.
REQ-029 The counter SHALL be $clog2(2N) bits wide and reset to 0 on entry to FEED and DRAIN.
REQ-030 result_q SHALL hold its value until the next DONE; no arithmetic is performed in this block.

Reset
REQ-031 reset=0 SHALL asynchronously force IDLE, counter=0, busy=0, done=0, arr_clr=0, a_feed=0, b_feed=0, result_q=0, and all A/B registers to 0.
REQ-032 reset asserted mid-run SHALL abort the run with no done pulse; after release, the block SHALL accept start normally.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the default N/DATA_W/ACC_W values, and the lane-packing index helper.
REQ-034 One sub-module, systolic_operand_buf, SHALL implement the A/B register files with write port and skewed read.
REQ-035 The array is instantiated outside this block; its active-high clear input SHALL be driven from arr_clr.

Verification
REQ-036 Case 1: A=[[1,2],[3,4]], B=[[1,2],[3,4]], start -> done at k+7, result_q=[[7,10],[15,22]]; feeds per cycle t0..t2 are a=(1,0)/(2,3)/(0,4) and b=(1,0)/(3,2)/(0,4).
REQ-037 Case 2: A=identity, B=[[5,6],[7,8]] -> result_q=[[5,6],[7,8]]; rerun without rewrite gives same result (accumulators cleared).
REQ-038 Case 3: start pulsed in FEED and DONE -> ignored, exactly one done; wr_en during busy leaves operands unchanged.
REQ-039 Case 4: reset=0 at FEED t=1 -> all outputs 0 immediately, no done; next start after reload of Case-1 operands -> [[7,10],[15,22]].
REQ-040 Case 5: all operands 0xFFFF -> each result_q element equals the array's 32-bit wrapped value 0xFFFC0002; back-to-back start in the IDLE cycle right after DONE produces a second done 3N+2 cycles later.
